fft_nsr_monitor: RTL and testbench

- Synthesizable, parametrised successor to the bench-side NSR check on the TopFFT output stream.
- Joins the FFT output stream with a reference-sample stream, lane by lane.
- Accumulates signal energy (sum of DUT re²+im²) and noise energy (sum of (DUT−ref)² on re and im) over one frame.
- At frame end, presents both totals on a result handshake; sits after TopFFT in on-chip self-test and in benches.

---
 rtl/fft_nsr_monitor_if.sv | 47 ++++
 rtl/fft_nsr_monitor.sv | 252 +++++++++++++++++++++++++
 tb/tb_fft_nsr_monitor.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_nsr_monitor_if.sv
// fft_nsr_monitor_if: bundles the FFT stream, the reference stream and the
// frame-result handshake of fft_nsr_monitor.
// Optional NSR_PEAK_ERR_EN adds the peak_err/peak_idx result fields.
interface fft_nsr_monitor_if #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAME_LEN = 4096,
    parameter int unsigned ACC_W     = 64
);
    localparam int unsigned BUS_W = LANES * 2 * DATA_W;
    localparam int unsigned IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic             dut_vld;
    logic             dut_rdy;
    logic [BUS_W-1:0] dut_data;
    logic             ref_vld;
    logic             ref_rdy;
    logic [BUS_W-1:0] ref_data;
    logic             res_vld;
    logic             res_rdy;
    logic [ACC_W-1:0] sig_acc;
    logic [ACC_W-1:0] noise_acc;
    logic             ovf;
    logic [15:0]      frame_cnt;
`ifdef NSR_PEAK_ERR_EN
    logic [DATA_W:0]  peak_err;
    logic [IDX_W-1:0] peak_idx;
`endif

    // Producer / result-consumer side.
    modport master (
        output dut_vld, dut_data, ref_vld, ref_data, res_rdy,
        input  dut_rdy, ref_rdy, res_vld, sig_acc, noise_acc, ovf, frame_cnt
`ifdef NSR_PEAK_ERR_EN
        , input peak_err, peak_idx
`endif
    );

    // Monitor side.
    modport slave (
        input  dut_vld, dut_data, ref_vld, ref_data, res_rdy,
        output dut_rdy, ref_rdy, res_vld, sig_acc, noise_acc, ovf, frame_cnt
`ifdef NSR_PEAK_ERR_EN
        , output peak_err, peak_idx
`endif
    );
endinterface

// File: rtl/fft_nsr_monitor.sv
// fft_nsr_monitor: joins the FFT output stream with a reference stream lane by
// lane and accumulates per-frame signal energy (sum re^2+im^2 of the FFT
// output) and noise energy (sum of squared DUT-ref differences).
// Optional feature macro NSR_PEAK_ERR_EN: adds peak |DUT-ref| and the sample
// index of its first occurrence.
module fft_nsr_monitor #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAME_LEN = 4096,
    parameter int unsigned ACC_W     = 64
) (
    input  logic             clk,
    input  logic             rst,
    fft_nsr_monitor_if.slave bus
);
    localparam int unsigned BEATS  = FRAME_LEN / LANES;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned NCOMP  = LANES * 2;
    localparam int unsigned CW     = DATA_W + 1;
    localparam int unsigned SQ_W   = 2 * DATA_W + 2;
    localparam int unsigned BUS_W  = LANES * 2 * DATA_W;
`ifdef NSR_PEAK_ERR_EN
    localparam int unsigned IDX_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              dut_rdy_c, ref_rdy_c, res_vld_c;
    logic              consume, handshake;

    // Stage 0: captured beats.
    logic             v0_q;
    logic [BUS_W-1:0] dut0_q, ref0_q;
    // Stage 1: sign-extended DUT components and DUT-ref differences.
    logic                       v1_q;
    logic [NCOMP-1:0][CW-1:0]   dx1_q, dx1_d, d1_q, d1_d;
    // Stage 2: per-beat energy sums.
    logic             v2_q;
    logic [ACC_W-1:0] sig2_q, sig2_d, noise2_q, noise2_d;
    logic signed [SQ_W-1:0] sq_sig, sq_noise;
    // Stage 3: frame accumulators.
    logic [ACC_W-1:0] sig_acc_q, sig_acc_d, noise_acc_q, noise_acc_d;
    logic [ACC_W:0]   sig_sum, noise_sum;
    logic             ovf_q, ovf_d;
    logic [15:0]      frame_cnt_q;

    assign consume   = (state_q == S_ACCUM) && bus.dut_vld && bus.ref_vld;
    assign handshake = (state_q == S_HOLD) && bus.res_rdy;

    // FSM state and beat counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next state, beat counting and handshake outputs.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        dut_rdy_c = 1'b0;
        ref_rdy_c = 1'b0;
        res_vld_c = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_ACCUM;
            S_ACCUM: begin
                // Each ready follows the other stream's valid so the streams
                // only ever advance together.
                dut_rdy_c = bus.ref_vld;
                ref_rdy_c = bus.dut_vld;
                if (consume) begin
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        beat_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            // Stage 2 may still hold the last beat; it lands in the
            // accumulators on the same edge that enters HOLD.
            S_DRAIN: if (!v0_q && !v1_q) state_d = S_HOLD;
            S_HOLD: begin
                res_vld_c = 1'b1;
                if (bus.res_rdy) state_d = S_ACCUM;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stage 1 combinational: sign extension and per-component difference.
    always_comb begin
        dx1_d = '0;
        d1_d  = '0;
        for (int unsigned c = 0; c < NCOMP; c++) begin
            dx1_d[c] = {dut0_q[c*DATA_W + DATA_W - 1], dut0_q[c*DATA_W +: DATA_W]};
            d1_d[c]  = dx1_d[c] - {ref0_q[c*DATA_W + DATA_W - 1], ref0_q[c*DATA_W +: DATA_W]};
        end
    end

    // Stage 2 combinational: squares summed over components and lanes.
    always_comb begin
        sig2_d   = '0;
        noise2_d = '0;
        sq_sig   = '0;
        sq_noise = '0;
        for (int unsigned c = 0; c < NCOMP; c++) begin
            sq_sig   = SQ_W'($signed(dx1_q[c])) * SQ_W'($signed(dx1_q[c]));
            sq_noise = SQ_W'($signed(d1_q[c])) * SQ_W'($signed(d1_q[c]));
            sig2_d   = sig2_d + {{(ACC_W - SQ_W){1'b0}}, sq_sig};
            noise2_d = noise2_d + {{(ACC_W - SQ_W){1'b0}}, sq_noise};
        end
    end

    // Stage 3 combinational: saturating accumulate, clear on result handshake.
    always_comb begin
        sig_acc_d   = sig_acc_q;
        noise_acc_d = noise_acc_q;
        ovf_d       = ovf_q;
        sig_sum     = {1'b0, sig_acc_q} + {1'b0, sig2_q};
        noise_sum   = {1'b0, noise_acc_q} + {1'b0, noise2_q};
        if (handshake) begin
            sig_acc_d   = '0;
            noise_acc_d = '0;
            ovf_d       = 1'b0;
        end else if (v2_q) begin
            if (sig_sum[ACC_W]) begin
                sig_acc_d = '1;
                ovf_d     = 1'b1;
            end else begin
                sig_acc_d = sig_sum[ACC_W-1:0];
            end
            if (noise_sum[ACC_W]) begin
                noise_acc_d = '1;
                ovf_d       = 1'b1;
            end else begin
                noise_acc_d = noise_sum[ACC_W-1:0];
            end
        end
    end

    // Pipeline registers, accumulators and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q        <= 1'b0;
            dut0_q      <= '0;
            ref0_q      <= '0;
            v1_q        <= 1'b0;
            dx1_q       <= '0;
            d1_q        <= '0;
            v2_q        <= 1'b0;
            sig2_q      <= '0;
            noise2_q    <= '0;
            sig_acc_q   <= '0;
            noise_acc_q <= '0;
            ovf_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            v0_q <= consume;
            if (consume) begin
                dut0_q <= bus.dut_data;
                ref0_q <= bus.ref_data;
            end
            v1_q <= v0_q;
            if (v0_q) begin
                dx1_q <= dx1_d;
                d1_q  <= d1_d;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                sig2_q   <= sig2_d;
                noise2_q <= noise2_d;
            end
            sig_acc_q   <= sig_acc_d;
            noise_acc_q <= noise_acc_d;
            ovf_q       <= ovf_d;
            if (handshake) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign bus.dut_rdy   = dut_rdy_c;
    assign bus.ref_rdy   = ref_rdy_c;
    assign bus.res_vld   = res_vld_c;
    assign bus.sig_acc   = sig_acc_q;
    assign bus.noise_acc = noise_acc_q;
    assign bus.ovf       = ovf_q;
    assign bus.frame_cnt = frame_cnt_q;

`ifdef NSR_PEAK_ERR_EN
    logic [BEAT_W-1:0] b0_q, b1_q;
    logic [CW-1:0]     mag;
    logic [CW-1:0]     pk2_q, pk2_d, peak_q, peak_d;
    logic [IDX_W-1:0]  pidx2_q, pidx2_d, peak_idx_q, peak_idx_d;

    // Per-beat peak magnitude; strict compare keeps the lowest lane on ties.
    always_comb begin
        pk2_d   = '0;
        pidx2_d = IDX_W'(b1_q) * IDX_W'(LANES);
        mag     = '0;
        for (int unsigned c = 0; c < NCOMP; c++) begin
            mag = d1_q[c][CW-1] ? (~d1_q[c] + 1'b1) : d1_q[c];
            if (mag > pk2_d) begin
                pk2_d   = mag;
                pidx2_d = IDX_W'(b1_q) * IDX_W'(LANES) + IDX_W'(c / 2);
            end
        end
    end

    // Frame peak; strict compare keeps the first occurrence across beats.
    always_comb begin
        peak_d     = peak_q;
        peak_idx_d = peak_idx_q;
        if (handshake) begin
            peak_d     = '0;
            peak_idx_d = '0;
        end else if (v2_q && (pk2_q > peak_q)) begin
            peak_d     = pk2_q;
            peak_idx_d = pidx2_q;
        end
    end

    // Beat index tracking and peak registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            b0_q       <= '0;
            b1_q       <= '0;
            pk2_q      <= '0;
            pidx2_q    <= '0;
            peak_q     <= '0;
            peak_idx_q <= '0;
        end else begin
            if (consume) b0_q <= beat_q;
            if (v0_q) b1_q <= b0_q;
            if (v1_q) begin
                pk2_q   <= pk2_d;
                pidx2_q <= pidx2_d;
            end
            peak_q     <= peak_d;
            peak_idx_q <= peak_idx_d;
        end
    end

    assign bus.peak_err = peak_q;
    assign bus.peak_idx = peak_idx_q;
`endif
endmodule

// File: tb/tb_fft_nsr_monitor.sv
// tb_fft_nsr_monitor: table-driven and randomized frames for fft_nsr_monitor,
// checked against a plain-arithmetic energy model.
module tb_fft_nsr_monitor;
    localparam int unsigned LANES     = 2;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned FRAME_LEN = 4;
    localparam int unsigned ACC_W     = 64;
    localparam int          BEATS     = FRAME_LEN / LANES;
    localparam int          NVEC      = 8;

    typedef struct packed {
        logic [3:0][15:0] dre;
        logic [3:0][15:0] dim;
        logic [3:0][15:0] rre;
        logic [3:0][15:0] rim;
        logic [1:0]       mode;   // 0 both valid, 1 ref_vld toggles, 2 random valids
        logic [63:0]      exp_sig;
        logic [63:0]      exp_noise;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_nsr_monitor_if #(.LANES(LANES), .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .ACC_W(ACC_W)) bus();

    fft_nsr_monitor #(.LANES(LANES), .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_fc   = 0;
    vec_t tbl [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_sig(input vec_t v);
        longint s = 0;
        longint a, b;
        for (int i = 0; i < FRAME_LEN; i++) begin
            a = longint'($signed(v.dre[i]));
            b = longint'($signed(v.dim[i]));
            s += a * a + b * b;
        end
        return s;
    endfunction

    function automatic logic [63:0] model_noise(input vec_t v);
        longint s = 0;
        longint a, b;
        for (int i = 0; i < FRAME_LEN; i++) begin
            a = longint'($signed(v.dre[i])) - longint'($signed(v.rre[i]));
            b = longint'($signed(v.dim[i])) - longint'($signed(v.rim[i]));
            s += a * a + b * b;
        end
        return s;
    endfunction

`ifdef NSR_PEAK_ERR_EN
    task automatic model_peak(input vec_t v, output longint pe, output int pi);
        longint a, b;
        pe = 0;
        pi = 0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            a = longint'($signed(v.dre[i])) - longint'($signed(v.rre[i]));
            b = longint'($signed(v.dim[i])) - longint'($signed(v.rim[i]));
            if (a < 0) a = -a;
            if (b < 0) b = -b;
            if (a > pe) begin pe = a; pi = i; end
            if (b > pe) begin pe = b; pi = i; end
        end
    endtask
`endif

    // Beat packing: lane k at [k*32 +: 32] as {im, re}; past-the-end beats carry junk.
    function automatic logic [63:0] pack(input logic [3:0][15:0] re, input logic [3:0][15:0] im, input int beat);
        logic [63:0] p;
        int idx;
        p = 64'h0BAD_0BAD_0BAD_0BAD;
        for (int k = 0; k < LANES; k++) begin
            idx = beat * LANES + k;
            if (idx < FRAME_LEN) begin
                p[k*32 +: 16]      = re[idx];
                p[k*32 + 16 +: 16] = im[idx];
            end
        end
        return p;
    endfunction

    task automatic send_frame(input vec_t v, input int stop_after, output int dn, output int rn);
        int   cyc;
        logic da, ra;
        cyc = 0;
        dn  = 0;
        rn  = 0;
        while (dn < stop_after && cyc < 400) begin
            bus.dut_vld  = (v.mode == 2) ? ($urandom_range(3) != 0) : 1'b1;
            bus.ref_vld  = (v.mode == 1) ? (cyc % 2 == 0) :
                           (v.mode == 2) ? ($urandom_range(3) != 0) : 1'b1;
            bus.dut_data = pack(v.dre, v.dim, dn);
            bus.ref_data = pack(v.rre, v.rim, rn);
            @(negedge clk);
            da = bus.dut_vld && bus.dut_rdy;
            ra = bus.ref_vld && bus.ref_rdy;
            chk("lockstep_accept", da, ra);
            if (!bus.ref_vld) chk("dut_rdy_gated", bus.dut_rdy, 1'b0);
            if (!bus.dut_vld) chk("ref_rdy_gated", bus.ref_rdy, 1'b0);
            tick();
            if (da) dn++;
            if (ra) rn++;
            cyc++;
        end
    endtask

    // Keep both valids high with junk so DRAIN must refuse them.
    task automatic wait_result();
        int k;
        bus.dut_vld  = 1'b1;
        bus.ref_vld  = 1'b1;
        bus.dut_data = 64'hDEAD_BEEF_DEAD_BEEF;
        bus.ref_data = 64'h1234_5678_9ABC_DEF0;
        #1;
        k = 0;
        while (!bus.res_vld && k < 20) begin
            chk("drain_dut_rdy", bus.dut_rdy, 1'b0);
            chk("drain_ref_rdy", bus.ref_rdy, 1'b0);
            tick();
            k++;
        end
        chk("res_latency", k, 3);
    endtask

    task automatic check_result(input vec_t v);
`ifdef NSR_PEAK_ERR_EN
        longint pe;
        int     pi;
`endif
        chk("res_vld", bus.res_vld, 1'b1);
        chk("sig_acc", bus.sig_acc, v.exp_sig);
        chk("noise_acc", bus.noise_acc, v.exp_noise);
        chk("ovf", bus.ovf, 1'b0);
        chk("frame_cnt_hold", bus.frame_cnt, exp_fc);
`ifdef NSR_PEAK_ERR_EN
        model_peak(v, pe, pi);
        chk("peak_err", bus.peak_err, pe);
        chk("peak_idx", bus.peak_idx, pi);
`endif
    endtask

    task automatic handshake();
        bus.res_rdy = 1'b1;
        tick();
        bus.res_rdy = 1'b0;
        bus.dut_vld = 1'b0;
        bus.ref_vld = 1'b1;
        #1;
        exp_fc = (exp_fc + 1) % 65536;
        chk("frame_cnt_inc", bus.frame_cnt, exp_fc);
        chk("res_vld_clr", bus.res_vld, 1'b0);
        chk("sig_acc_clr", bus.sig_acc, 64'd0);
        chk("noise_acc_clr", bus.noise_acc, 64'd0);
        chk("ovf_clr", bus.ovf, 1'b0);
        chk("rdy_reassert", bus.dut_rdy, 1'b1);
        chk("ref_rdy_needs_dut_vld", bus.ref_rdy, 1'b0);
        bus.ref_vld = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int dn, rn;
        send_frame(v, BEATS, dn, rn);
        chk({tag, "_dut_beats"}, dn, BEATS);
        chk({tag, "_ref_beats"}, rn, BEATS);
        wait_result();
        check_result(v);
        handshake();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dn, rn;
        vec_t v0;

        // Stimulus table: fixed cases carry hand-derived totals, random ones use the model.
        for (int i = 0; i < NVEC; i++) tbl[i] = '0;
        for (int j = 0; j < FRAME_LEN; j++) begin
            tbl[0].dre[j] = 16'd1;  tbl[0].rre[j] = 16'd1;
            tbl[1].dre[j] = 16'd3;  tbl[1].rre[j] = 16'd1;
            tbl[3].dre[j] = 16'd1;  tbl[3].rre[j] = 16'd1;
        end
        tbl[0].exp_sig = 64'd4;          tbl[0].exp_noise = 64'd0;
        tbl[1].exp_sig = 64'd36;         tbl[1].exp_noise = 64'd16;
        tbl[2].dre[0]  = 16'h8000;       tbl[2].rre[0]    = 16'h7FFF;
        tbl[2].exp_sig = 64'd1073741824; tbl[2].exp_noise = 64'd4294836225;
        tbl[3].mode    = 2'd1;
        tbl[3].exp_sig = 64'd4;          tbl[3].exp_noise = 64'd0;
        for (int i = 4; i < NVEC; i++) begin
            for (int j = 0; j < FRAME_LEN; j++) begin
                tbl[i].dre[j] = 16'($urandom());
                tbl[i].dim[j] = 16'($urandom());
                tbl[i].rre[j] = (i == 4) ? tbl[i].dre[j] + 16'($urandom_range(7)) : 16'($urandom());
                tbl[i].rim[j] = 16'($urandom());
            end
            tbl[i].mode      = 2'd2;
            tbl[i].exp_sig   = model_sig(tbl[i]);
            tbl[i].exp_noise = model_noise(tbl[i]);
        end
        v0 = tbl[0];

        rst          = 1'b1;
        bus.dut_vld  = 1'b0;
        bus.ref_vld  = 1'b0;
        bus.res_rdy  = 1'b0;
        bus.dut_data = '0;
        bus.ref_data = '0;
        tick();
        tick();
        chk("rst_dut_rdy", bus.dut_rdy, 1'b0);
        chk("rst_ref_rdy", bus.ref_rdy, 1'b0);
        chk("rst_res_vld", bus.res_vld, 1'b0);
        chk("rst_sig_acc", bus.sig_acc, 64'd0);
        chk("rst_noise_acc", bus.noise_acc, 64'd0);
        chk("rst_ovf", bus.ovf, 1'b0);
        chk("rst_frame_cnt", bus.frame_cnt, 16'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Back-pressure: result and readies frozen while res_rdy stays low.
        send_frame(tbl[1], BEATS, dn, rn);
        chk("bp_beats", dn, BEATS);
        wait_result();
        for (int c = 0; c < 10; c++) begin
            chk("bp_res_vld", bus.res_vld, 1'b1);
            chk("bp_sig_acc", bus.sig_acc, 64'd36);
            chk("bp_noise_acc", bus.noise_acc, 64'd16);
            chk("bp_dut_rdy", bus.dut_rdy, 1'b0);
            chk("bp_ref_rdy", bus.ref_rdy, 1'b0);
            tick();
        end
        check_result(tbl[1]);
        handshake();
        run_vec(v0, "after_bp");

        // Reset after one of two beats: partial frame discarded.
        send_frame(v0, 1, dn, rn);
        chk("partial_beats", dn, 1);
        bus.dut_vld = 1'b1;
        bus.ref_vld = 1'b1;
        rst = 1'b1;
        tick();
        exp_fc = 0;
        chk("mid_rst_dut_rdy", bus.dut_rdy, 1'b0);
        chk("mid_rst_ref_rdy", bus.ref_rdy, 1'b0);
        chk("mid_rst_res_vld", bus.res_vld, 1'b0);
        chk("mid_rst_sig_acc", bus.sig_acc, 64'd0);
        chk("mid_rst_noise_acc", bus.noise_acc, 64'd0);
        chk("mid_rst_ovf", bus.ovf, 1'b0);
        chk("mid_rst_frame_cnt", bus.frame_cnt, 16'd0);
        rst = 1'b0;
        run_vec(v0, "post_rst");
        chk("post_rst_frame_cnt", bus.frame_cnt, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
